// File: rtl/w5500_spi_arbiter.sv
// rtl/w5500_spi_arbiter.sv - Round-robin arbiter sharing one W5500 SPI engine between two frame requesters
module w5500_spi_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        req0_valid,
    input  logic        req0_last,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_last,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        spi_valid,
    output logic        spi_last,
    output logic [31:0] spi_data,
    input  logic        spi_ready,
    input  logic        spi_done,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data_out,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_ABORT,
        S_WAIT_DONE
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  gnt_nx;
    logic        ptr;
    logic        ptr_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [15:0] cnt_inc;
    logic        tmo_nx;
    logic        tmo_hit;
    logic        sel_valid;
    logic        sel_last;
    logic [31:0] sel_data;
    logic        accept;

    // ptr = 0 favours req0, ptr = 1 favours req1
    assign sel_valid = gnt[1] ? req1_valid : req0_valid;
    assign sel_last  = gnt[1] ? req1_last  : req0_last;
    assign sel_data  = gnt[1] ? req1_data  : req0_data;
    assign accept    = (state == S_OWN) && sel_valid && spi_ready;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign tmo_hit = (cnt_inc == TMO);

    assign busy         = (state != S_IDLE);
    assign rsp0_valid   = busy && rsp_valid && gnt[0];
    assign rsp1_valid   = busy && rsp_valid && gnt[1];
    assign rsp_data_out = (busy && rsp_valid) ? rsp_data : 32'h0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= S_IDLE;
            gnt         <= 2'b00;
            ptr         <= 1'b0;
            cnt         <= 16'h0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            gnt         <= gnt_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            timeout_err <= tmo_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        ptr_nx     = ptr;
        tmo_nx     = 1'b0;
        spi_valid  = 1'b0;
        spi_last   = 1'b0;
        spi_data   = 32'h0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_nx = S_OWN;
                    if (req0_valid && (!req1_valid || !ptr)) begin
                        gnt_nx = 2'b01;
                    end else begin
                        gnt_nx = 2'b10;
                    end
                end
            end
            S_OWN: begin
                spi_valid  = sel_valid;
                spi_last   = sel_last;
                spi_data   = sel_data;
                req0_ready = gnt[0] && spi_ready;
                req1_ready = gnt[1] && spi_ready;
                if (accept && sel_last) begin
                    state_nx = S_WAIT_DONE;
                end else if (!accept && tmo_hit) begin
                    state_nx = S_ABORT;
                    tmo_nx   = 1'b1;
                end
            end
            S_ABORT: begin
                // Closing beat lets the engine finish the frame and release chip select
                spi_valid = 1'b1;
                spi_last  = 1'b1;
                if (spi_ready) begin
                    state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (spi_done || tmo_hit) begin
                    state_nx = S_IDLE;
                    gnt_nx   = 2'b00;
                    ptr_nx   = gnt[0];
                    tmo_nx   = !spi_done;
                end
            end
            default: begin
                state_nx = S_IDLE;
                gnt_nx   = 2'b00;
            end
        endcase
    end

    always_comb begin
        cnt_nx = cnt;
        if ((state_nx != state) || accept) begin
            cnt_nx = 16'h0;
        end else if ((state == S_OWN) || (state == S_WAIT_DONE)) begin
            cnt_nx = cnt_inc;
        end
    end

endmodule

// File: tb/tb_w5500_spi_arbiter.sv
// tb/tb_w5500_spi_arbiter.sv - Directed plus randomized frame checks of the W5500 SPI arbiter
module tb_w5500_spi_arbiter;

    localparam int TMO = 16;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        req0_valid, req0_last, req1_valid, req1_last;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        spi_valid, spi_last, spi_ready, spi_done;
    logic [31:0] spi_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data_out;
    logic [1:0]  gnt;
    logic        busy, timeout_err;

    int total = 0;
    int bad = 0;
    int last_owner;

    w5500_spi_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .req0_valid(req0_valid), .req0_last(req0_last), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_last(req1_last), .req1_data(req1_data), .req1_ready(req1_ready),
        .spi_valid(spi_valid), .spi_last(spi_last), .spi_data(spi_data), .spi_ready(spi_ready),
        .spi_done(spi_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data_out(rsp_data_out),
        .gnt(gnt), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic drive_req(input int who, input logic v, input logic [31:0] d, input logic l);
        if (who == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    function automatic logic rdy_of(input int who);
        return (who != 0) ? req1_ready : req0_ready;
    endfunction

    // Model: the pointer favours whichever requester did not hold the last tenure
    task automatic expect_grant(output int w);
        if (req0_valid && req1_valid) w = (last_owner == 0) ? 1 : 0;
        else w = req1_valid ? 1 : 0;
        #1;
        check("idle_spi_valid", spi_valid, 0);
        check("idle_ready0", req0_ready, 0);
        check("idle_ready1", req1_ready, 0);
        check("idle_busy", busy, 0);
        step();
        check("grant", gnt, (w != 0) ? 2 : 1);
        check("grant_busy", busy, 1);
    endtask

    task automatic run_frame(input int who, input int nbeats, input int mode,
                             input logic other_v, input bit rsp_rand);
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        int   sent = 0;
        int   cyc = 0;
        int   streak = 0;
        logic tog = 1'b1;
        logic v, r;
        for (int i = 0; i < nbeats; i++) exp_q.push_back($urandom);
        while (sent < nbeats && cyc < 300) begin
            v = 1'b1;
            r = 1'b1;
            if (mode == 1) begin
                r = tog;
                tog = ~tog;
            end
            if (mode == 2) begin
                v = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 1);
                if (streak >= 8) begin
                    v = 1'b1;
                    r = 1'b1;
                end
            end
            drive_req(who, v, exp_q[sent], sent == nbeats - 1);
            drive_req(1 - who, other_v, $urandom, 1'b0);
            spi_ready = r;
            rsp_valid = rsp_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            rsp_data  = $urandom;
            #1;
            check("own_gnt", gnt, (who != 0) ? 2 : 1);
            check("own_spi_valid", spi_valid, v);
            check("own_ready", rdy_of(who), r);
            check("other_ready", rdy_of(1 - who), 0);
            if (rsp_rand) begin
                check("own_rsp0", rsp0_valid, rsp_valid && who == 0);
                check("own_rsp1", rsp1_valid, rsp_valid && who == 1);
                if (rsp_valid) check("own_rsp_data", rsp_data_out, rsp_data);
            end
            if (spi_valid && spi_ready) begin
                obs_q.push_back(spi_data);
                check("own_last", spi_last, obs_q.size() == nbeats);
            end
            if (v && r) begin
                sent++;
                streak = 0;
            end else begin
                streak++;
            end
            step();
            cyc++;
        end
        check("frame_budget", sent, nbeats);
        drive_req(who, 1'b0, 32'h0, 1'b0);
        spi_ready = 1'b0;
        rsp_valid = 1'b0;
        check("beat_count", obs_q.size(), nbeats);
        for (int i = 0; i < nbeats && i < obs_q.size(); i++) check("beat_data", obs_q[i], exp_q[i]);
    endtask

    task automatic finish_frame(input int who, input int delay);
        for (int i = 0; i < delay; i++) begin
            #1;
            check("wait_busy", busy, 1);
            check("wait_spi_valid", spi_valid, 0);
            check("wait_ready", rdy_of(who), 0);
            check("wait_gnt", gnt, (who != 0) ? 2 : 1);
            step();
        end
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        #1;
        check("done_busy", busy, 0);
        check("done_gnt", gnt, 0);
        check("done_tmo", timeout_err, 0);
        last_owner = who;
    endtask

    initial begin
        int w;
        int pat;
        reset_reset_n = 1'b0;
        req0_valid = 1'b1; req0_last = 1'b0; req0_data = 32'h1111_0000;
        req1_valid = 1'b1; req1_last = 1'b0; req1_data = 32'h2222_0000;
        spi_ready = 1'b1; spi_done = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        last_owner = 1;
        repeat (3) @(posedge clk_clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_spi_valid", spi_valid, 0);
        check("rst_spi_last", spi_last, 0);
        check("rst_spi_data", spi_data, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp0", rsp0_valid, 0);
        check("rst_rsp1", rsp1_valid, 0);
        check("rst_rsp_data", rsp_data_out, 0);
        check("rst_tmo", timeout_err, 0);

        // Both requesting out of reset: req0 first, then req1 by round-robin
        rsp_valid = 1'b0;
        reset_reset_n = 1'b1;
        expect_grant(w);
        check("first_gnt", gnt, 2'b01);
        run_frame(0, 3, 0, 1'b1, 1'b0);
        finish_frame(0, 2);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        expect_grant(w);
        check("second_gnt", gnt, 2'b10);

        // req1 four beats under a toggling ready, req0 kept requesting
        run_frame(1, 4, 1, 1'b1, 1'b0);
        rsp_valid = 1'b1;
        rsp_data = 32'hA5A5_0001;
        #1;
        check("rsp_own_rsp1", rsp1_valid, 1);
        check("rsp_own_rsp0", rsp0_valid, 0);
        check("rsp_own_data", rsp_data_out, 32'hA5A5_0001);
        step();
        rsp_valid = 1'b0;
        req0_valid = 1'b0;
        finish_frame(1, 1);
        rsp_valid = 1'b1;
        #1;
        check("rsp_idle_rsp0", rsp0_valid, 0);
        check("rsp_idle_rsp1", rsp1_valid, 0);
        step();
        rsp_valid = 1'b0;

        // Owner stalls after one beat; a stray spi_done in OWN must be ignored
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        expect_grant(w);
        req0_data = 32'h0BAD_0001;
        req0_last = 1'b0;
        spi_ready = 1'b1;
        #1;
        check("stall_beat1", spi_data, 32'h0BAD_0001);
        step();
        req0_valid = 1'b0;
        spi_ready = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            spi_done = (i == 3);
            #1;
            check("stall_tmo", timeout_err, 0);
            check("stall_busy", busy, 1);
            check("stall_gnt", gnt, 2'b01);
            check("stall_spi_valid", spi_valid, 0);
            step();
        end
        spi_done = 1'b0;
        #1;
        check("abort_tmo", timeout_err, 1);
        check("abort_valid", spi_valid, 1);
        check("abort_last", spi_last, 1);
        check("abort_data", spi_data, 0);
        step();
        req0_valid = 1'b1;
        req0_data = 32'hFFFF_FFFF;
        spi_ready = 1'b1;
        #1;
        check("abort2_tmo", timeout_err, 0);
        check("abort2_valid", spi_valid, 1);
        check("abort2_data", spi_data, 0);
        check("abort2_ready0", req0_ready, 0);
        step();
        req0_valid = 1'b0;
        spi_ready = 1'b0;
        finish_frame(0, 1);

        // No spi_done after the last beat: watchdog returns to IDLE
        req1_valid = 1'b1;
        expect_grant(w);
        check("wd_gnt", gnt, 2'b10);
        run_frame(1, 2, 0, 1'b0, 1'b0);
        for (int i = 1; i <= TMO; i++) begin
            #1;
            check("wd_busy", busy, 1);
            check("wd_tmo", timeout_err, 0);
            step();
        end
        #1;
        check("wd_idle", busy, 0);
        check("wd_tmo_pulse", timeout_err, 1);
        check("wd_gnt_clr", gnt, 0);
        last_owner = 1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        expect_grant(w);
        check("wd_ptr_gnt", gnt, 2'b01);
        run_frame(0, 1, 0, 1'b1, 1'b0);
        finish_frame(0, 0);

        // Reset during beat 2 of a req0 frame
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        expect_grant(w);
        req0_data = 32'hC0C0_0000;
        spi_ready = 1'b1;
        step();
        req0_data = 32'hC0C0_0001;
        rsp_valid = 1'b1;
        #1;
        check("mid_beat2", spi_data, 32'hC0C0_0001);
        reset_reset_n = 1'b0;
        #1;
        check("mrst_spi_valid", spi_valid, 0);
        check("mrst_spi_data", spi_data, 0);
        check("mrst_spi_last", spi_last, 0);
        check("mrst_gnt", gnt, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready0", req0_ready, 0);
        check("mrst_rsp0", rsp0_valid, 0);
        check("mrst_rsp_data", rsp_data_out, 0);
        check("mrst_tmo", timeout_err, 0);
        step();
        check("mrst_no_abort", spi_valid, 0);
        rsp_valid = 1'b0;
        req1_valid = 1'b1;
        reset_reset_n = 1'b1;
        last_owner = 1;
        expect_grant(w);
        check("post_rst_gnt", gnt, 2'b01);
        run_frame(0, 2, 0, 1'b1, 1'b0);
        finish_frame(0, 1);

        // Randomized frames against the round-robin model
        for (int f = 0; f < 30; f++) begin
            pat = $urandom_range(1, 3);
            req0_valid = pat[0];
            req1_valid = pat[1];
            expect_grant(w);
            run_frame(w, $urandom_range(1, 5), 2, (w != 0) ? pat[0] : pat[1], 1'b1);
            finish_frame(w, $urandom_range(0, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
